// File: rtl/barrel_pkg.sv
// Shared shift-mode encodings for the pipelined barrel shifter.
// No logic; types only.
// Imported by the stage and top modules.
package barrel_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSR = 2'b00,  // logical right, zero fill
    SHIFT_ASR = 2'b01,  // arithmetic right, sign fill
    SHIFT_LSL = 2'b10,  // logical left, zero fill
    SHIFT_ROR = 2'b11   // rotate right
  } shift_mode_e;

endpackage

// File: rtl/barrel_stage.sv
// One combinational shift-by-DIST step with sticky accumulation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline register decides when to capture.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  shift_mode_e      mode,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_sticky,
  output logic [WIDTH-1:0] res_data,
  output logic             res_sticky
);

  // Rotation distance folded into the word so large stage distances still wrap.
  localparam int ROT = DIST % WIDTH;

  // Bits that fall off the LSB end of a right shift by DIST.
  function automatic logic [WIDTH-1:0] low_mask();
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < DIST) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] LOST_MASK = low_mask();

  // Apply the shift when this stage's shamt bit is set; otherwise pass through.
  // For arithmetic right, any sign-fill bit that reaches the discard window
  // implies the original sign bit was discarded too, so OR-ing the whole
  // window still yields the sticky of original bits only.
  always_comb begin
    res_data   = src_data;
    res_sticky = src_sticky;
    if (en) begin
      unique case (mode)
        SHIFT_LSR: begin
          res_data   = src_data >> DIST;
          res_sticky = src_sticky | (|(src_data & LOST_MASK));
        end
        SHIFT_ASR: begin
          res_data   = $signed(src_data) >>> DIST;
          res_sticky = src_sticky | (|(src_data & LOST_MASK));
        end
        SHIFT_LSL: begin
          res_data = src_data << DIST;
        end
        SHIFT_ROR: begin
          res_data = (src_data >> ROT) | (src_data << (WIDTH - ROT));
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shift.sv
// Pipelined barrel shifter (LSR/ASR/LSL/ROR) with FP-alignment sticky output.
// Latency: SHAMT_W cycles from input transfer to out_valid; one beat per cycle.
// Backpressure: valid/ready; a stage loads when empty or when its successor loads.
module pipelined_barrel_shift
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky
);

  // shamt holds only the bits still to be applied; each stage consumes bit 0.
  typedef struct packed {
    logic               vld;
    shift_mode_e        mode;
    logic [SHAMT_W-1:0] shamt;
    logic               sticky;
    logic [WIDTH-1:0]   data;
  } stage_t;

  stage_t           stg_q       [SHAMT_W];
  stage_t           stg_src     [SHAMT_W];
  logic [WIDTH-1:0] step_data   [SHAMT_W];
  logic             step_sticky [SHAMT_W];
  logic [SHAMT_W:0] ld;

  // Source of each stage: the input port for stage 0, the previous register otherwise.
  always_comb begin
    stg_src[0] = '{vld: in_valid, mode: shift_mode_e'(in_mode), shamt: in_shamt,
                   sticky: 1'b0, data: in_data};
    for (int k = 1; k < SHAMT_W; k++) begin
      stg_src[k] = stg_q[k-1];
    end
  end

  // Load chain: a stage advances when empty or when the stage after it advances.
  always_comb begin
    ld[SHAMT_W] = out_ready;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      ld[k] = !stg_q[k].vld || ld[k+1];
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_step
    barrel_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** k)
    ) u_stage (
      .en         (stg_src[k].shamt[0]),
      .mode       (stg_src[k].mode),
      .src_data   (stg_src[k].data),
      .src_sticky (stg_src[k].sticky),
      .res_data   (step_data[k]),
      .res_sticky (step_sticky[k])
    );
  end

  // Stage registers; reset empties the whole pipe and zeroes the output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (ld[k]) begin
          stg_q[k] <= '{vld: stg_src[k].vld, mode: stg_src[k].mode,
                        shamt: stg_src[k].shamt >> 1, sticky: step_sticky[k],
                        data: step_data[k]};
        end
      end
    end
  end

  assign in_ready   = ld[0];
  assign out_valid  = stg_q[SHAMT_W-1].vld;
  assign out_data   = stg_q[SHAMT_W-1].data;
  assign out_sticky = stg_q[SHAMT_W-1].sticky;

endmodule

// File: tb/tb_pipelined_barrel_shift.sv
// Bench for pipelined_barrel_shift at WIDTH=8 and WIDTH=24 with a bit-level reference model.
module tb_pipelined_barrel_shift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit instance
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sticky;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_in_shamt;
  logic [1:0] a_in_mode;

  // 24-bit instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sticky;
  logic [23:0] b_in_data, b_out_data;
  logic [4:0]  b_in_shamt;
  logic [1:0]  b_in_mode;

  pipelined_barrel_shift #(.WIDTH(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sticky(a_out_sticky)
  );

  pipelined_barrel_shift #(.WIDTH(24)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sticky(b_out_sticky)
  );

  int n_vec = 0;
  int n_err = 0;
  int b_rx  = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each output bit computed from its source bit position; result is {sticky, data}.
  function automatic logic [64:0] model(input logic [63:0] d, input int s, input int m, input int w);
    logic [63:0] r;
    logic        st;
    logic        fill;
    r    = '0;
    st   = 1'b0;
    fill = (m == 1) ? d[w-1] : 1'b0;
    for (int j = 0; j < w; j++) begin
      case (m)
        0, 1:    r[j] = (j + s < w) ? d[j+s] : fill;
        2:       r[j] = (j >= s) ? d[j-s] : 1'b0;
        default: r[j] = d[(j + s) % w];
      endcase
    end
    if (m < 2) begin
      for (int j = 0; j < w && j < s; j++) st = st | d[j];
    end
    return {st, r};
  endfunction

  // Scoreboard: push model results on input transfer, compare on output transfer,
  // and require a stalled output to stay put.
  logic [64:0] qa[$];
  logic [64:0] qb[$];
  logic        b_stall = 1'b0;
  logic [23:0] b_hold_d;
  logic        b_hold_s;

  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        qa.delete();
        qb.delete();
        b_stall = 1'b0;
      end else begin
        if (b_stall) begin
          check("b_stall_valid", b_out_valid, 1);
          check("b_stall_data", b_out_data, b_hold_d);
          check("b_stall_sticky", b_out_sticky, b_hold_s);
        end
        if (a_in_valid && a_in_ready) qa.push_back(model(a_in_data, a_in_shamt, a_in_mode, 8));
        if (b_in_valid && b_in_ready) qb.push_back(model(b_in_data, b_in_shamt, b_in_mode, 24));
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) begin
            check("a_unexpected_beat", a_out_valid, 0);
          end else begin
            e = qa.pop_front();
            check("a_model_data", a_out_data, e[7:0]);
            check("a_model_sticky", a_out_sticky, e[64]);
          end
        end
        if (b_out_valid && b_out_ready) begin
          if (qb.size() == 0) begin
            check("b_unexpected_beat", b_out_valid, 0);
          end else begin
            e = qb.pop_front();
            check("b_model_data", b_out_data, e[23:0]);
            check("b_model_sticky", b_out_sticky, e[64]);
            b_rx++;
          end
        end
        b_stall  = b_out_valid && !b_out_ready;
        b_hold_d = b_out_data;
        b_hold_s = b_out_sticky;
      end
    end
  end

  // One beat with literal expectations, latency measurement and a model cross-check.
  task automatic directed(input string name, input bit wide, input logic [23:0] d, input int s,
                          input int m, input logic [23:0] exp_d, input logic exp_s);
    int          lat;
    int          want;
    logic        v;
    logic [64:0] mdl;
    want = wide ? 5 : 3;
    mdl  = model({40'h0, d}, s, m, wide ? 24 : 8);
    check({name, "_model"}, mdl, {exp_s, 40'h0, exp_d});
    @(posedge clk); #1;
    if (wide) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_shamt = s[4:0]; b_in_mode = m[1:0];
    end else begin
      a_in_valid = 1'b1; a_in_data = d[7:0]; a_in_shamt = s[2:0]; a_in_mode = m[1:0];
    end
    @(negedge clk);
    check({name, "_in_ready"}, wide ? b_in_ready : a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 0;
    v   = 1'b0;
    while (!v && lat < 20) begin
      @(negedge clk);
      lat++;
      v = wide ? b_out_valid : a_out_valid;
    end
    check({name, "_latency"}, lat, want);
    check({name, "_data"}, wide ? b_out_data : {16'h0, a_out_data}, exp_d);
    check({name, "_sticky"}, wide ? b_out_sticky : a_out_sticky, exp_s);
  endtask

  // Offer one beat to the 24-bit instance; called and returns at posedge+1.
  task automatic send_b(input logic [23:0] d, input logic [4:0] s, input logic [1:0] m);
    int w;
    w = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_shamt = s; b_in_mode = m;
    @(negedge clk);
    while (!b_in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!b_in_ready) check("send_b_timeout", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_b();
    int c;
    c = 0;
    while (qb.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("b_drain", qb.size(), 0);
  endtask

  initial begin
    time t0;
    int  start;
    int  seen;
    logic [31:0] r;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_mode = '0; b_out_ready = 1'b1;

    #12;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_data", b_out_data, 0);
    check("rst_b_out_sticky", b_out_sticky, 0);
    #11 rst = 1'b0;
    @(negedge clk);
    check("post_rst_b_in_ready", b_in_ready, 1);
    check("post_rst_a_in_ready", a_in_ready, 1);

    // Directed vectors, WIDTH=8
    directed("a_lsr3", 1'b0, 24'hB4, 3, 0, 24'h16, 1'b1);
    directed("a_asr2", 1'b0, 24'hB4, 2, 1, 24'hED, 1'b0);
    directed("a_ror3", 1'b0, 24'hB4, 3, 3, 24'h96, 1'b0);
    directed("a_asr0", 1'b0, 24'hB4, 0, 1, 24'hB4, 1'b0);
    directed("a_lsl5", 1'b0, 24'hB4, 5, 2, 24'h80, 1'b0);

    // Directed vectors, WIDTH=24
    directed("b_lsr31", 1'b1, 24'h800001, 31, 0, 24'h000000, 1'b1);
    directed("b_lsl4",  1'b1, 24'h800001, 4,  2, 24'h000010, 1'b0);
    directed("b_asr31", 1'b1, 24'h800001, 31, 1, 24'hFFFFFF, 1'b1);
    directed("b_ror25", 1'b1, 24'h800001, 25, 3, 24'hC00000, 1'b0);
    directed("b_asr4",  1'b1, 24'hF00000, 4,  1, 24'hFF0000, 1'b0);
    directed("b_lsl31", 1'b1, 24'hFFFFFF, 31, 2, 24'h000000, 1'b0);

    // Full throughput with out_ready held high.
    @(posedge clk); #1;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      send_b(r[23:0], 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    end
    check("throughput_cycles", ($time - t0) / 10, 8);
    drain_b();

    // Back-pressure: out_ready toggles every 2 cycles while 10 beats stream.
    @(posedge clk); #1;
    start = b_rx;
    b_out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          r = $urandom;
          send_b(r[23:0], 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
      end
      begin
        int c;
        c = 0;
        while (b_rx - start < 10 && c < 400) begin
          @(posedge clk); #1;
          c++;
          if (c % 2 == 0) b_out_ready = ~b_out_ready;
        end
      end
    join
    check("bp_results", b_rx - start, 10);
    b_out_ready = 1'b1;
    drain_b();

    // Reset with 3 beats in flight and the oldest stalled at the output.
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    send_b(24'h123456, 5'd3, 2'd0);
    send_b(24'hABCDEF, 5'd7, 2'd1);
    send_b(24'h0F0F0F, 5'd9, 2'd3);
    @(posedge clk);
    @(posedge clk); #2;
    check("midrst_pre_valid", b_out_valid, 1);
    rst = 1'b1;
    b_out_ready = 1'b1;
    #1;
    check("midrst_out_valid", b_out_valid, 0);
    check("midrst_out_data", b_out_data, 0);
    check("midrst_out_sticky", b_out_sticky, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", b_in_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_out_valid) seen++;
    end
    check("midrst_no_stale", seen, 0);

    // Pipe still works after the reset.
    directed("b_after_rst", 1'b1, 24'h800001, 31, 0, 24'h000000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
